// File: rtl/mux_rr_arb.sv
// N:1 registered mux with valid/ready per channel and fixed or round-robin select.
// Ports: CLK, Reset_L (async, active-low); in/in_valid/in_ready producer side;
// sel, mode (0 fixed, 1 round-robin); out/out_chan/out_valid/out_ready consumer side;
// in_last only with MUX_LOCK_EN defined (packet lock until final beat).
module mux_rr_arb #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               CLK,
  input  logic               Reset_L,
  input  logic [N*WIDTH-1:0] in,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
`ifdef MUX_LOCK_EN
  input  logic [N-1:0]       in_last,
`endif
  input  logic [SELW-1:0]    sel,
  input  logic               mode,
  output logic [WIDTH-1:0]   out,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [SELW-1:0]  chan_q, chan_d;
  logic             vld_q, vld_d;
  logic [SELW-1:0]  last_q, last_d;

  logic             load;
  logic             xfer;
  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic [SELW-1:0]  rr_grant;
  logic             rr_valid;
  logic             fx_valid;
  logic [WIDTH-1:0] gdata;

  assign load = !vld_q || out_ready;
  assign xfer = load && grant_valid;

  // scan last+1 .. N-1, 0 .. last; first valid channel wins
  always_comb begin
    int idx;
    idx      = 0;
    rr_grant = '0;
    rr_valid = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(last_q) + i;
      if (idx >= N) idx = idx - N;
      if (!rr_valid && in_valid[idx]) begin
        rr_valid = 1'b1;
        rr_grant = SELW'(idx);
      end
    end
  end

  always_comb begin
    fx_valid = 1'b0;
    if (int'(sel) < N) fx_valid = in_valid[sel];
  end

`ifdef MUX_LOCK_EN
  logic            lock_q, lock_d;
  logic [SELW-1:0] lock_ch_q, lock_ch_d;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (lock_q) begin
      grant       = lock_ch_q;
      grant_valid = in_valid[lock_ch_q];
    end else if (mode) begin
      grant       = rr_grant;
      grant_valid = rr_valid;
    end else begin
      grant       = sel;
      grant_valid = fx_valid;
    end
  end

  always_comb begin
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (xfer) begin
      lock_d    = !in_last[grant];
      lock_ch_d = grant;
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`else
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (mode) begin
      grant       = rr_grant;
      grant_valid = rr_valid;
    end else begin
      grant       = sel;
      grant_valid = fx_valid;
    end
  end
`endif

  // loop select keeps an out-of-range grant from indexing past the bus
  always_comb begin
    gdata = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(grant) == k) gdata = in[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int k = 0; k < N; k++) begin
      in_ready[k] = xfer && (int'(grant) == k);
    end
  end

  always_comb begin
    out_d  = out_q;
    chan_d = chan_q;
    vld_d  = vld_q;
    last_d = last_q;
    if (load) begin
      vld_d = grant_valid;
      if (grant_valid) begin
        out_d  = gdata;
        chan_d = grant;
      end
    end
    if (xfer && mode) last_d = grant;
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      out_q  <= '0;
      chan_q <= '0;
      vld_q  <= 1'b0;
      last_q <= SELW'(N - 1);
    end else begin
      out_q  <= out_d;
      chan_q <= chan_d;
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  assign out       = out_q;
  assign out_chan  = chan_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed bench for mux_rr_arb (N=4, WIDTH=8).
// Covers fixed select, round-robin order, stall, async reset and packet lock.
module tb_mux_rr_arb;

  logic        CLK;
  logic        Reset_L;
  logic [31:0] in;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
`ifdef MUX_LOCK_EN
  logic [3:0]  in_last;
`endif
  logic [1:0]  sel;
  logic        mode;
  logic [7:0]  out;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  mux_rr_arb #(.WIDTH(8), .N(4), .SELW(2)) dut (
    .CLK       (CLK),
    .Reset_L   (Reset_L),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef MUX_LOCK_EN
    .in_last   (in_last),
`endif
    .sel       (sel),
    .mode      (mode),
    .out       (out),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [1:0] rr_exp [8];
  logic [1:0] alt_exp [3];
  logic [7:0] bytes [4];

  initial begin
    rr_exp  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    alt_exp = '{2'd1, 2'd3, 2'd1};
    bytes   = '{8'h11, 8'h22, 8'h33, 8'h44};
    Reset_L   = 1'b0;
    in        = 32'h44332211;
    in_valid  = 4'h0;
    sel       = 2'd0;
    mode      = 1'b0;
    out_ready = 1'b1;
`ifdef MUX_LOCK_EN
    in_last   = 4'hf;
`endif
    #12;
    chk("rst_out", {24'd0, out}, 32'd0);
    chk("rst_chan", {30'd0, out_chan}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    Reset_L = 1'b1;
    tick();

    // fixed select
    in_valid = 4'hf;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk("t1_ready", {28'd0, in_ready}, 32'(1 << s));
      tick();
      chk("t1_out", {24'd0, out}, {24'd0, bytes[s]});
      chk("t1_chan", {30'd0, out_chan}, 32'(s));
      chk("t1_valid", {31'd0, out_valid}, 32'd1);
    end

    // round-robin from reset
    in_valid = 4'h0;
    #2;
    Reset_L = 1'b0;
    #3;
    Reset_L = 1'b1;
    tick();
    mode     = 1'b1;
    in_valid = 4'hf;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("t2_ready", {28'd0, in_ready}, 32'(1 << rr_exp[c]));
      tick();
      chk("t2_chan", {30'd0, out_chan}, {30'd0, rr_exp[c]});
      chk("t2_out", {24'd0, out}, {24'd0, bytes[rr_exp[c]]});
    end

    // sparse valid
    in_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t3_chan", {30'd0, out_chan}, {30'd0, alt_exp[c]});
      chk("t3_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 4'h0;
    #1;
    chk("t3_idle_ready", {28'd0, in_ready}, 32'd0);
    tick();
    chk("t3_fall", {31'd0, out_valid}, 32'd0);
    chk("t3_hold", {24'd0, out}, 32'h22);
    chk("t3_hold_chan", {30'd0, out_chan}, 32'd1);

    // stall
    mode     = 1'b0;
    sel      = 2'd1;
    in_valid = 4'hf;
    tick();
    chk("t4_load", {24'd0, out}, 32'h22);
    out_ready = 1'b0;
    sel       = 2'd2;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_stall_ready", {28'd0, in_ready}, 32'd0);
      tick();
      chk("t4_stall_out", {24'd0, out}, 32'h22);
      chk("t4_stall_chan", {30'd0, out_chan}, 32'd1);
      chk("t4_stall_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("t4_resume_ready", {28'd0, in_ready}, 32'h4);
    tick();
    chk("t4_resume_out", {24'd0, out}, 32'h33);
    sel = 2'd3;
    tick();
    chk("t4_next_out", {24'd0, out}, 32'h44);

    // async reset mid-stream
    mode = 1'b1;
    tick();
    #2;
    Reset_L = 1'b0;
    #1;
    chk("t5_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_out", {24'd0, out}, 32'd0);
    chk("t5_chan", {30'd0, out_chan}, 32'd0);
    #2;
    Reset_L = 1'b1;
    #1;
    chk("t5_ready", {28'd0, in_ready}, 32'h1);
    tick();
    chk("t5_first", {30'd0, out_chan}, 32'd0);
    chk("t5_first_out", {24'd0, out}, 32'h11);

`ifdef MUX_LOCK_EN
    // packet lock on channel 2
    mode    = 1'b0;
    sel     = 2'd2;
    in_last = 4'h0;
    tick();
    chk("t6_b1", {30'd0, out_chan}, 32'd2);
    mode = 1'b1;
    sel  = 2'd0;
    #1;
    chk("t6_lock_ready", {28'd0, in_ready}, 32'h4);
    tick();
    chk("t6_b2", {30'd0, out_chan}, 32'd2);
    in_last = 4'h4;
    tick();
    chk("t6_b3", {30'd0, out_chan}, 32'd2);
    in_last = 4'hf;
    tick();
    chk("t6_rr3", {30'd0, out_chan}, 32'd3);
    tick();
    chk("t6_rr0", {30'd0, out_chan}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
